// File: rtl/queue_counter.sv
// queue_counter: counts customers in a single bank queue using two photocells.
// Each raw sensor is synchronised, debounced and rising-edge detected. The
// events then drive a saturating up/down counter with registered full/empty
// flags and one-cycle overflow/underflow pulses.
module queue_counter #(
    parameter int N          = 3,
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         back_sensor,
    input  logic         front_sensor,
    output logic [N-1:0] pcount,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic         unf
);

    localparam int DCW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [N-1:0]   PMAX    = {N{1'b1}};

    // Index 0 is the entrance (back) sensor, index 1 the teller-end (front) sensor.
    logic [1:0] raw;
    logic [1:0] ev;

    assign raw = {front_sensor, back_sensor};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            logic           s1_reg;
            logic           s2_reg;
            logic           deb_reg;
            logic           deb_q_reg;
            logic [DCW-1:0] dc_reg;

            // Synchroniser, debouncer and edge-history flops for one sensor.
            // A new level must persist in s2 for DEB_CYCLES edges to be accepted.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_q_reg <= 1'b0;
                    dc_reg    <= '0;
                end else begin
                    s1_reg    <= raw[gi];
                    s2_reg    <= s1_reg;
                    deb_q_reg <= deb_reg;
                    if (s2_reg == deb_reg) begin
                        dc_reg <= '0;
                    end else if (dc_reg == DC_LAST) begin
                        deb_reg <= s2_reg;
                        dc_reg  <= '0;
                    end else begin
                        dc_reg <= dc_reg + 1'b1;
                    end
                end
            end

            // Only a beam being blocked (rising debounced level) is an arrival.
            assign ev[gi] = deb_reg & ~deb_q_reg;
        end
    endgenerate

    logic         enter;
    logic         leave;
    logic [N-1:0] pcount_next;
    logic         ovf_next;
    logic         unf_next;

    assign enter = ev[0];
    assign leave = ev[1];

    // Next count with saturation; simultaneous entry/exit nets to zero except
    // when the queue is empty, where only the entry is physically possible.
    always_comb begin
        pcount_next = pcount;
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        if (enter && leave) begin
            if (empty) begin
                pcount_next = pcount + 1'b1;
            end
        end else if (enter) begin
            if (full) begin
                ovf_next = 1'b1;
            end else begin
                pcount_next = pcount + 1'b1;
            end
        end else if (leave) begin
            if (empty) begin
                unf_next = 1'b1;
            end else begin
                pcount_next = pcount - 1'b1;
            end
        end
    end

    // Count and flags are registered from the same next value so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcount <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            pcount <= pcount_next;
            full   <= (pcount_next == PMAX);
            empty  <= (pcount_next == '0);
            ovf    <= ovf_next;
            unf    <= unf_next;
        end
    end

endmodule

// File: tb/tb_queue_counter.sv
// tb_queue_counter: directed test-plan scenarios with literal expectations,
// then randomized sensor activity, all checked every cycle against a
// behavioural model of the queue.
module tb_queue_counter;

    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int MAXC = 7;

    logic         clk          = 1'b0;
    logic         rst          = 1'b0;
    logic         back_sensor  = 1'b0;
    logic         front_sensor = 1'b0;
    logic [N-1:0] pcount;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         unf;

    int n_checks = 0;
    int n_err    = 0;
    int ovf_cnt  = 0;
    int unf_cnt  = 0;
    bit cmp_en   = 1'b0;

    queue_counter #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .back_sensor (back_sensor),
        .front_sensor(front_sensor),
        .pcount      (pcount),
        .full        (full),
        .empty       (empty),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist[i][0] is the latest raw sample, hist[i][1..DEB] the synchronised
    // samples the debouncer judges. A level is accepted once the last DEB
    // synchronised samples all differ from the accepted level.
    bit hist [2][DEB+1];
    bit m_deb [2];
    bit m_deb_prev [2];
    int exp_cnt = 0;
    bit exp_ovf = 1'b0;
    bit exp_unf = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j <= DEB; j++) hist[i][j] = 1'b0;
            m_deb[i]      = 1'b0;
            m_deb_prev[i] = 1'b0;
        end
        exp_cnt = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic model_step();
        bit evs [2];
        bit flip;
        bit raw_now;
        for (int i = 0; i < 2; i++) begin
            evs[i]        = m_deb[i] && !m_deb_prev[i];
            m_deb_prev[i] = m_deb[i];
        end
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        if (evs[0] && evs[1]) begin
            if (exp_cnt == 0) exp_cnt = 1;
        end else if (evs[0]) begin
            if (exp_cnt == MAXC) exp_ovf = 1'b1;
            else exp_cnt = exp_cnt + 1;
        end else if (evs[1]) begin
            if (exp_cnt == 0) exp_unf = 1'b1;
            else exp_cnt = exp_cnt - 1;
        end
        for (int i = 0; i < 2; i++) begin
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++)
                if (hist[i][k] == m_deb[i]) flip = 1'b0;
            if (flip) m_deb[i] = !m_deb[i];
            raw_now = (i == 0) ? (back_sensor === 1'b1) : (front_sensor === 1'b1);
            for (int j = DEB; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw_now;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [N-1:0] exp_p;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                exp_p = exp_cnt[N-1:0];
                n_checks++;
                if ({pcount, full, empty, ovf, unf} !==
                    {exp_p, (exp_cnt == MAXC), (exp_cnt == 0), exp_ovf, exp_unf}) begin
                    n_err++;
                    $display("FAIL cycle_cmp t=%0t: pcount=%0d full=%b empty=%b ovf=%b unf=%b, expected pcount=%0d full=%b empty=%b ovf=%b unf=%b",
                             $time, pcount, full, empty, ovf, unf,
                             exp_cnt, (exp_cnt == MAXC), (exp_cnt == 0), exp_ovf, exp_unf);
                end
            end
        end
    end

    // Counts pulse cycles of ovf/unf, sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ovf === 1'b1) ovf_cnt++;
            if (unf === 1'b1) unf_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic check_lit(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Drives a pulse starting at the current falling edge: hi edges high, lo edges low.
    task automatic pulse(input bit b, input bit f, input int hi, input int lo);
        back_sensor  = b;
        front_sensor = f;
        repeat (hi) @(negedge clk);
        back_sensor  = 1'b0;
        front_sensor = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulses(input bit b, input bit f, input int cnt);
        for (int i = 0; i < cnt; i++) pulse(b, f, 10, 10);
    endtask

    initial begin
        int o0;
        int u0;
        int len_b;
        int len_f;

        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check_lit("reset_pcount", int'(pcount), 0);
        check_lit("reset_empty", int'(empty), 1);
        check_lit("reset_full", int'(full), 0);
        rst = 1'b0;

        // Basic count: increments land 6 edges after the raw rise.
        for (int i = 0; i < 3; i++) begin
            back_sensor = 1'b1;
            repeat (6) @(negedge clk);
            check_lit("basic_before_lat", int'(pcount), i);
            @(negedge clk);
            check_lit("basic_after_lat", int'(pcount), i + 1);
            if (i == 0) check_lit("basic_empty_falls", int'(empty), 0);
            repeat (3) @(negedge clk);
            back_sensor = 1'b0;
            repeat (10) @(negedge clk);
        end

        // Fill and overflow.
        pulses(1'b1, 1'b0, 4);
        check_lit("fill_pcount", int'(pcount), 7);
        check_lit("fill_full", int'(full), 1);
        check_lit("model_fill", exp_cnt, 7);
        o0 = ovf_cnt;
        pulses(1'b1, 1'b0, 1);
        check_lit("ovf_pcount", int'(pcount), 7);
        check_lit("ovf_one_cycle", ovf_cnt - o0, 1);

        // Drain and underflow.
        pulses(1'b0, 1'b1, 5);
        check_lit("drain_to2", int'(pcount), 2);
        u0 = unf_cnt;
        pulses(1'b0, 1'b1, 2);
        check_lit("drain_to0", int'(pcount), 0);
        check_lit("drain_empty", int'(empty), 1);
        check_lit("drain_no_unf", unf_cnt - u0, 0);
        pulses(1'b0, 1'b1, 1);
        check_lit("unf_pcount", int'(pcount), 0);
        check_lit("unf_one_cycle", unf_cnt - u0, 1);

        // Glitch rejection, then the shortest accepted pulse.
        o0 = ovf_cnt;
        u0 = unf_cnt;
        pulse(1'b1, 1'b0, 3, 10);
        pulse(1'b0, 1'b1, 2, 10);
        check_lit("glitch_pcount", int'(pcount), 0);
        check_lit("glitch_no_pulses", (ovf_cnt - o0) + (unf_cnt - u0), 0);
        pulse(1'b1, 1'b0, 4, 10);
        check_lit("min_pulse_counts", int'(pcount), 1);

        // Simultaneous events at 0, 4 and 7.
        pulses(1'b0, 1'b1, 1);
        u0 = unf_cnt;
        pulses(1'b1, 1'b1, 1);
        check_lit("simul_at0", int'(pcount), 1);
        check_lit("simul_at0_no_unf", unf_cnt - u0, 0);
        pulses(1'b1, 1'b0, 3);
        check_lit("simul_pre4", int'(pcount), 4);
        pulses(1'b1, 1'b1, 1);
        check_lit("simul_at4", int'(pcount), 4);
        pulses(1'b1, 1'b0, 3);
        o0 = ovf_cnt;
        pulses(1'b1, 1'b1, 1);
        check_lit("simul_at7", int'(pcount), 7);
        check_lit("simul_at7_no_ovf", ovf_cnt - o0, 0);

        // Reset mid-debounce with back held high through release.
        pulses(1'b0, 1'b1, 2);
        check_lit("rst_pre5", int'(pcount), 5);
        back_sensor = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_lit("rst_async_pcount", int'(pcount), 0);
        check_lit("rst_async_empty", int'(empty), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_lit("rst_release_before", int'(pcount), 0);
        @(negedge clk);
        check_lit("rst_release_after", int'(pcount), 1);
        back_sensor = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized sensor activity with occasional asynchronous resets.
        len_b = 1;
        len_f = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            len_b = len_b - 1;
            if (len_b == 0) begin
                back_sensor = ~back_sensor;
                len_b = int'($urandom_range(1, 12));
            end
            len_f = len_f - 1;
            if (len_f == 0) begin
                front_sensor = ~front_sensor;
                len_f = int'($urandom_range(1, 14));
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        back_sensor  = 1'b0;
        front_sensor = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/queue_counter.md
# queue_counter

Tracks the number of customers waiting in the single-bank queue from two photocell sensors: one at the queue entrance (back) and one at the teller end (front). Each raw sensor is synchronised, debounced and edge-detected. A saturating up/down counter then produces `pcount` plus full and empty flags. `pcount` drives the low address bits of the waiting-time ROM, and the flags drive the front-panel indicators.

## Interface
- `N`, default 3: width of `pcount`. Maximum queue occupancy is `2**N-1`, which is 7 at the default.
- `DEB_CYCLES`, default 4: number of consecutive stable cycles required before a sensor level is accepted. Must be at least 1.
- `clk`, input, 1: system clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `back_sensor`, input, 1: raw entrance photocell, asynchronous. 1 means the beam is blocked.
- `front_sensor`, input, 1: raw teller-end photocell, asynchronous. 1 means the beam is blocked.
- `pcount`, output, N: registered number of persons in the queue.
- `full`, output, 1: registered flag, 1 iff `pcount == 2**N-1`.
- `empty`, output, 1: registered flag, 1 iff `pcount == 0`.
- `ovf`, output, 1: one-cycle pulse when an entry is rejected because the queue is full.
- `unf`, output, 1: one-cycle pulse when an exit is rejected because the queue is empty.

## Operation
- **Reset** (async, `rst=1`): clear all synchroniser flops, debounced levels, debounce counters and edge-history flops. Outputs are `pcount=0`, `empty=1`, `full=0`, `ovf=0`, `unf=0`. State holds while `rst` is high. Normal operation resumes on the first rising edge after `rst` falls.
- **Synchroniser:** each sensor passes through a 2-flop chain, `s1` then `s2`.
- **Debouncer** (one per sensor): holds the debounced level `deb` and a counter `dc` of width `$clog2(DEB_CYCLES+1)`.
  - If `s2 == deb`, then `dc <= 0`.
  - Otherwise `dc <= dc+1`.
  - When `dc == DEB_CYCLES-1` and `s2 != deb`, then `deb <= s2` and `dc <= 0`.
  - Result: a level different from `deb` must be seen in `s2` for `DEB_CYCLES` consecutive edges before it is accepted. Shorter glitches are discarded.
- **Edge detect:** `deb_q <= deb`. The event is `ev = deb & ~deb_q`, which is combinational and one cycle wide. Only rising edges count: a person arriving at a sensor. Beam release is ignored.
- **Counter:** `enter = ev_back` and `leave = ev_front` are evaluated every edge in the following priority.
  - `enter & leave`:
    - If `empty`: `pcount+1`, `unf` stays 0. Nobody can leave an empty queue, so only the entry applies.
    - Otherwise: `pcount` unchanged. At full, the exit frees the slot for the entry, so `ovf` stays 0.
  - `enter` only:
    - If `full`: `pcount` unchanged, `ovf <= 1` for one cycle.
    - Otherwise: `pcount+1`.
  - `leave` only:
    - If `empty`: `pcount` unchanged, `unf <= 1` for one cycle.
    - Otherwise: `pcount-1`.
  - Neither: hold.
  - `pcount` never wraps. All arithmetic is N-bit with explicit saturation checks.
- **Flags:** `full` and `empty` are registered from the next-state value of `pcount`, so they always agree with `pcount` in the same cycle. `ovf` and `unf` default to 0 every cycle.

## Timing
- E0 is the first rising edge at which a raw sensor is sampled at 1 (`s1=1`). Then:
  - `s2=1` at E1.
  - `deb=1` at E(DEB_CYCLES+1).
  - `ev` is high during the following cycle.
  - `pcount`, the flags, `ovf` and `unf` update at E(DEB_CYCLES+2).
- Minimum accepted pulse: `DEB_CYCLES` cycles high as seen at `s2`. The raw signal must then stay low for at least `DEB_CYCLES` cycles before a second arrival counts.
- Throughput: at most one count event per sensor per debounced high/low pair.
- `ovf` and `unf` are exactly one cycle wide, aligned with the edge on which the rejected event would have applied.
- Asserting `rst` mid-debounce discards the pending event. After release, a sensor still held at 1 produces a fresh event after the full latency.

## Test plan
- **Basic count:** reset, then 3 back pulses of 10 cycles separated by 10 cycles low (DEB_CYCLES=4) -> `pcount` 0→1→2→3. Each increment lands 6 edges after the raw rise. `empty` falls with the first increment.
- **Fill and overflow:** 8 back pulses -> `pcount=7` and `full=1` after the 7th. On the 8th, `pcount` stays 7 and `ovf` pulses for exactly one cycle.
- **Drain and underflow:** from 2, 3 front pulses -> `pcount` 2→1→0, `empty=1`. The 3rd pulse gives `unf` for one cycle and `pcount` stays 0.
- **Glitch rejection:** back pulse 3 cycles wide, then a front pulse 2 cycles wide -> no change in `pcount`, `ovf` or `unf`. A back pulse exactly 4 cycles wide (as seen at `s2`) -> `pcount+1`.
- **Simultaneous events:** identical back and front pulses at `pcount` = 0, 4 and 7. Required results: 0→1 with no `unf`; 4→4; 7→7 with no `ovf`.
- **Reset mid-operation:** assert `rst` asynchronously (between clock edges) with `pcount=5` and a back pulse 2 cycles into debounce -> `pcount=0`, `empty=1` immediately. Hold back high through release -> `pcount=1` 6 edges after the first post-reset sample.
